// File: rtl/vector_store_pkg.sv
// Shared definitions for the vector_store block: default geometry, width
// helpers and the control FSM state encoding.
package vector_store_pkg;

   localparam int unsigned DATA_WIDTH_DFLT = 7;
   localparam int unsigned DATA_COUNT_DFLT = 127;

   // Index width for a given capacity (at least one bit).
   function automatic int unsigned idx_width(input int unsigned count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   // Length width: must represent 0..count inclusive.
   function automatic int unsigned len_width(input int unsigned count);
      return $clog2(count + 1);
   endfunction

   localparam int unsigned IW = idx_width(DATA_COUNT_DFLT);
   localparam int unsigned LW = len_width(DATA_COUNT_DFLT);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SHIFT_UP   = 2'd1,
      ST_SHIFT_DOWN = 2'd2
   } state_e;

endpackage

// File: rtl/vector_store_if.sv
// Command/response bundle between the text buffer (master) and the
// vector store (slave).
interface vector_store_if
   import vector_store_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter int unsigned DATA_COUNT = DATA_COUNT_DFLT
);

   localparam int unsigned IDX_W = idx_width(DATA_COUNT);
   localparam int unsigned LEN_W = len_width(DATA_COUNT);

   logic [IDX_W-1:0]      index;
   logic                  get;
   logic                  insert;
   logic                  remove;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic [LEN_W-1:0]      length;
   logic                  ready;

   modport master (
      output index, get, insert, remove, data_in,
      input  data_out, length, ready
   );

   modport slave (
      input  index, get, insert, remove, data_in,
      output data_out, length, ready
   );

endinterface

// File: rtl/vector_store_mem.sv
// Element storage: single write port, one combinational read port. The
// read port is shared between indexed gets and the neighbour fetch used
// while shifting, so it must be combinational to move one word per clock.
module vector_store_mem
   import vector_store_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter  int unsigned DATA_COUNT = DATA_COUNT_DFLT,
   localparam int unsigned IDX_W      = idx_width(DATA_COUNT)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DATA_COUNT];

   // Write port; contents carry no reset value.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Addresses past the end (e.g. j+1 on the last element) read as zero.
   assign rdata_o = (32'(raddr_i) < DATA_COUNT) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/vector_store.sv
// Ordered variable-length word array with positional insert/remove and
// indexed read. Insert and remove shift one element per clock.
module vector_store
   import vector_store_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter int unsigned DATA_COUNT = DATA_COUNT_DFLT
) (
   input  logic         clk,
   input  logic         rst,
   vector_store_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(DATA_COUNT);
   localparam int unsigned LEN_W = len_width(DATA_COUNT);
   localparam logic [LEN_W-1:0] FULL = LEN_W'(DATA_COUNT);

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      j_q, j_d;
   logic [LEN_W-1:0]      tgt_q, tgt_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;

   logic                  mem_we;
   logic [IDX_W-1:0]      mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [IDX_W-1:0]      mem_raddr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic [LEN_W-1:0]      idx_ext;
   logic [LEN_W-1:0]      j_dec;
   logic [LEN_W-1:0]      j_inc;
   logic [LEN_W-1:0]      len_dec;

   assign idx_ext = LEN_W'(bus.index);
   assign j_dec   = j_q - LEN_W'(1);
   assign j_inc   = j_q + LEN_W'(1);
   assign len_dec = len_q - LEN_W'(1);

   vector_store_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_COUNT (DATA_COUNT)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   // State and datapath registers; reset aborts any shift and empties the vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         j_q     <= '0;
         tgt_q   <= '0;
         din_q   <= '0;
         len_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         tgt_q   <= tgt_d;
         din_q   <= din_d;
         len_q   <= len_d;
         dout_q  <= dout_d;
      end
   end

   // Command decode and shift sequencing. Priority is decided on the raw
   // pulses: a remove request masks insert/get in the same cycle even when
   // the remove itself turns out to be out of range.
   always_comb begin
      state_d   = state_q;
      j_d       = j_q;
      tgt_d     = tgt_q;
      din_d     = din_q;
      len_d     = len_q;
      dout_d    = dout_q;
      mem_we    = 1'b0;
      mem_waddr = j_q[IDX_W-1:0];
      mem_wdata = mem_rdata;
      mem_raddr = bus.index;

      case (state_q)
         ST_IDLE: begin
            if (bus.remove) begin
               if (idx_ext < len_q) begin
                  tgt_d   = idx_ext;
                  j_d     = idx_ext;
                  state_d = ST_SHIFT_DOWN;
               end
            end else if (bus.insert) begin
               if ((len_q != FULL) && (idx_ext <= len_q)) begin
                  tgt_d   = idx_ext;
                  din_d   = bus.data_in;
                  j_d     = len_q;
                  state_d = ST_SHIFT_UP;
               end
            end else if (bus.get) begin
               dout_d = (idx_ext < len_q) ? mem_rdata : '0;
            end
         end

         // Walk j down from the old end, copying mem[j-1] into mem[j],
         // then drop the new word into the hole at tgt.
         ST_SHIFT_UP: begin
            mem_raddr = j_dec[IDX_W-1:0];
            mem_we    = 1'b1;
            if (j_q == tgt_q) begin
               mem_wdata = din_q;
               len_d     = len_q + LEN_W'(1);
               state_d   = ST_IDLE;
            end else begin
               j_d = j_dec;
            end
         end

         // Walk j up from tgt, copying mem[j+1] into mem[j]; the stale
         // last slot is simply dropped by shrinking length.
         ST_SHIFT_DOWN: begin
            mem_raddr = j_inc[IDX_W-1:0];
            if (j_q == len_dec) begin
               len_d   = len_dec;
               state_d = ST_IDLE;
            end else begin
               mem_we = 1'b1;
               j_d    = j_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.data_out = dout_q;
   assign bus.length   = len_q;
   assign bus.ready    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vector_store.sv
// Directed bench for vector_store: a table of command vectors with
// hand-computed results, plus fill, full-boundary, priority and
// mid-shift reset sequences.
module tb_vector_store;

   localparam int DW = 7;
   localparam int DC = 127;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vector_store_if #(.DATA_WIDTH(DW), .DATA_COUNT(DC)) bus();

   vector_store #(.DATA_WIDTH(DW), .DATA_COUNT(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   typedef enum int {OP_GET, OP_INS, OP_REM} op_e;

   typedef struct {
      op_e op;
      int  idx;
      int  din;
      int  exp_busy;
      int  exp_len;
      int  exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle command pulse; returns #1 after the edge that samples it.
   task automatic drive(input logic g, input logic ins, input logic rem,
                        input int idx, input int din);
      bus.get     = g;
      bus.insert  = ins;
      bus.remove  = rem;
      bus.index   = 7'(idx);
      bus.data_in = 7'(din);
      step();
      bus.get     = 1'b0;
      bus.insert  = 1'b0;
      bus.remove  = 1'b0;
   endtask

   // Counts cycles with ready low following a command pulse.
   task automatic wait_idle(output int busy);
      busy = 0;
      while (bus.ready !== 1'b1 && busy < 400) begin
         step();
         busy++;
      end
      if (busy >= 400) begin
         check("idle_timeout", int'(bus.ready), 1);
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int busy;
      case (v.op)
         OP_GET: begin
            drive(1'b1, 1'b0, 1'b0, v.idx, 0);
            check($sformatf("vec%0d_get%0d_data", n, v.idx), int'(bus.data_out), v.exp_data);
            check($sformatf("vec%0d_len", n), int'(bus.length), v.exp_len);
         end
         OP_INS: begin
            drive(1'b0, 1'b1, 1'b0, v.idx, v.din);
            wait_idle(busy);
            check($sformatf("vec%0d_ins%0d_busy", n, v.idx), busy, v.exp_busy);
            check($sformatf("vec%0d_len", n), int'(bus.length), v.exp_len);
         end
         default: begin
            drive(1'b0, 1'b0, 1'b1, v.idx, 0);
            wait_idle(busy);
            check($sformatf("vec%0d_rem%0d_busy", n, v.idx), busy, v.exp_busy);
            check($sformatf("vec%0d_len", n), int'(bus.length), v.exp_len);
         end
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int busy;
      bus.get     = 1'b0;
      bus.insert  = 1'b0;
      bus.remove  = 1'b0;
      bus.index   = '0;
      bus.data_in = '0;

      // op, idx, din, busy, len, data      A=41 B=42 C=43 X=58
      vecs.push_back('{OP_GET, 0, 0,    0, 0, 8'h00});
      vecs.push_back('{OP_INS, 0, 'h41, 1, 1, 0});
      vecs.push_back('{OP_GET, 0, 0,    0, 1, 'h41});
      vecs.push_back('{OP_INS, 1, 'h42, 1, 2, 0});
      vecs.push_back('{OP_INS, 2, 'h43, 1, 3, 0});
      vecs.push_back('{OP_INS, 1, 'h58, 3, 4, 0});
      vecs.push_back('{OP_GET, 0, 0,    0, 4, 'h41});
      vecs.push_back('{OP_GET, 1, 0,    0, 4, 'h58});
      vecs.push_back('{OP_GET, 2, 0,    0, 4, 'h42});
      vecs.push_back('{OP_GET, 3, 0,    0, 4, 'h43});
      vecs.push_back('{OP_GET, 4, 0,    0, 4, 'h00});
      vecs.push_back('{OP_REM, 0, 0,    4, 3, 0});
      vecs.push_back('{OP_GET, 0, 0,    0, 3, 'h58});
      vecs.push_back('{OP_GET, 1, 0,    0, 3, 'h42});
      vecs.push_back('{OP_GET, 2, 0,    0, 3, 'h43});
      vecs.push_back('{OP_GET, 3, 0,    0, 3, 'h00});
      vecs.push_back('{OP_REM, 3, 0,    0, 3, 0});
      vecs.push_back('{OP_INS, 5, 'h55, 0, 3, 0});
      vecs.push_back('{OP_REM, 2, 0,    1, 2, 0});
      vecs.push_back('{OP_GET, 2, 0,    0, 2, 'h00});
      vecs.push_back('{OP_INS, 0, 'h43, 3, 3, 0});
      vecs.push_back('{OP_GET, 0, 0,    0, 3, 'h43});
      vecs.push_back('{OP_GET, 1, 0,    0, 3, 'h58});
      vecs.push_back('{OP_GET, 2, 0,    0, 3, 'h42});

      // Reset, then idle state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check("reset_length", int'(bus.length), 0);
      check("reset_ready", int'(bus.ready), 1);
      check("reset_data_out", int'(bus.data_out), 0);

      foreach (vecs[i]) begin
         run_vec(vecs[i], i);
      end

      // data_out holds without a get.
      step();
      step();
      check("dout_hold", int'(bus.data_out), 'h42);

      // Fresh empty vector, then fill to capacity with appends.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step();
      check("rst2_length", int'(bus.length), 0);
      for (int p = 0; p < DC; p++) begin
         drive(1'b0, 1'b1, 1'b0, p, (p * 3 + 5) & 127);
         wait_idle(busy);
         check($sformatf("fill%0d_busy", p), busy, 1);
      end
      check("full_length", int'(bus.length), DC);

      // Insert into a full vector is ignored.
      drive(1'b0, 1'b1, 1'b0, 0, 'h11);
      check("full_ins_ready", int'(bus.ready), 1);
      wait_idle(busy);
      check("full_ins_busy", busy, 0);
      check("full_ins_length", int'(bus.length), DC);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      check("full_get0", int'(bus.data_out), 5);
      drive(1'b1, 1'b0, 1'b0, 126, 0);
      check("full_get126", int'(bus.data_out), 'h7F);

      // Insert and remove together at 0: remove wins.
      drive(1'b0, 1'b1, 1'b1, 0, 'h22);
      check("prio_ready_low", int'(bus.ready), 0);
      wait_idle(busy);
      check("prio_busy", busy, 127);
      check("prio_length", int'(bus.length), 126);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      check("prio_get0", int'(bus.data_out), 8);
      drive(1'b1, 1'b0, 1'b0, 126, 0);
      check("prio_get126", int'(bus.data_out), 0);
      drive(1'b1, 1'b0, 1'b0, 125, 0);
      check("prio_get125", int'(bus.data_out), 'h7F);

      // Reset in the middle of a long SHIFT_UP.
      drive(1'b0, 1'b1, 1'b0, 0, 'h33);
      check("midshift_ready_low", int'(bus.ready), 0);
      repeat (5) step();
      check("midshift_still_busy", int'(bus.ready), 0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_length", int'(bus.length), 0);
      check("async_rst_ready", int'(bus.ready), 1);
      check("async_rst_data_out", int'(bus.data_out), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      check("post_rst_get0", int'(bus.data_out), 0);
      check("post_rst_length", int'(bus.length), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
